// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NCH valid/ready requesters.
// Grants bursts of up to BURST beats; accepted words reach the FIFO through one register stage.
module fifo_wr_arbiter #(
    parameter int NCH   = 4,
    parameter int DW    = 24,
    parameter int BURST = 4,
    parameter int CW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    i_valid,
    input  logic [NCH*DW-1:0] i_data,
    output logic [NCH-1:0]    o_ready,
    output logic              o_wr,
    output logic [DW-1:0]     o_wdata,
    input  logic              i_wfull,
    output logic [NCH-1:0]    o_grant,
    output logic [CW-1:0]     o_chan
);

    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   r_gnt;
    logic [CNTW-1:0] r_cnt;
    logic [NCH-1:0]  r_grant;
    logic            r_wr;
    logic [DW-1:0]   r_wdata;
    logic [CW-1:0]   r_chan;

    logic [CW-1:0]   w_pick;
    logic            w_found;
    logic            w_xfer;
    logic            w_done;
    logic [DW-1:0]   w_selData;

    // Search starts one past the last served channel so every requester gets its turn.
    always_comb begin
        int idx;
        idx     = 0;
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(r_ptr) + i) % NCH;
            if (!w_found && i_valid[CW'(idx)]) begin
                w_pick  = CW'(idx);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_gnt == CW'(k)) begin
                w_selData = i_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = GRANT;
            GRANT:   if (w_done)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A full FIFO freezes the grant entirely: no transfer, no yield, no timeout.
    always_comb begin
        o_ready = '0;
        w_xfer  = 1'b0;
        w_done  = 1'b0;
        if (r_state == GRANT) begin
            o_ready[r_gnt] = ~i_wfull;
            w_xfer         = i_valid[r_gnt] & ~i_wfull;
            w_done         = (w_xfer && (r_cnt == CNTW'(BURST - 1))) ||
                             (!i_valid[r_gnt] && !i_wfull);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= CW'(NCH - 1);
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_chan  <= '0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_gnt   <= w_pick;
                r_cnt   <= '0;
                r_grant <= NCH'(1) << w_pick;
            end else if (w_done) begin
                r_ptr   <= r_gnt;
                r_grant <= '0;
            end
            if (w_xfer) begin
                r_cnt   <= r_cnt + 1'b1;
                r_wdata <= w_selData;
                r_chan  <= r_gnt;
            end
            r_wr <= w_xfer;
        end
    end

    assign o_wr    = r_wr;
    assign o_wdata = r_wdata;
    assign o_chan  = r_chan;
    assign o_grant = r_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-channel BURST=4 instance and a 2-channel BURST=1 instance.
// Expected grants and beats are hand-derived cycle by cycle; sources advance on valid&ready.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [95:0] data;
    logic [3:0]  ready;
    logic        wr;
    logic [23:0] wdata;
    logic        wfull;
    logic [3:0]  grant;
    logic [1:0]  chan;

    logic [1:0]  validB;
    logic [15:0] dataB;
    logic [1:0]  readyB;
    logic        wrB;
    logic [7:0]  wdataB;
    logic        wfullB;
    logic [1:0]  grantB;
    logic [0:0]  chanB;

    logic [3:0]  srcEn;
    int          seq  [4];
    int          lim  [4];
    int          base [4];

    int nAsserts;
    int nFail;

    fifo_wr_arbiter #(.NCH(4), .DW(24), .BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (valid),
        .i_data  (data),
        .o_ready (ready),
        .o_wr    (wr),
        .o_wdata (wdata),
        .i_wfull (wfull),
        .o_grant (grant),
        .o_chan  (chan)
    );

    fifo_wr_arbiter #(.NCH(2), .DW(8), .BURST(1)) dutB1 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (validB),
        .i_data  (dataB),
        .o_ready (readyB),
        .o_wr    (wrB),
        .o_wdata (wdataB),
        .i_wfull (wfullB),
        .o_grant (grantB),
        .o_chan  (chanB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: bench did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic driveSources;
        for (int k = 0; k < 4; k++) begin
            valid[k]         = srcEn[k] && (seq[k] < lim[k]);
            data[k*24 +: 24] = 24'(base[k] + seq[k]);
        end
    endtask

    task automatic clearSources;
        for (int k = 0; k < 4; k++) begin
            seq[k]  = 0;
            lim[k]  = 0;
            base[k] = 0;
        end
    endtask

    // One clock step; a source advances only when its beat was accepted outside reset.
    task automatic applyStimulus;
        logic [3:0] acc;
        @(negedge clk);
        acc = ready & valid & {4{rst}};
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) seq[k]++;
        end
        driveSources();
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expWr, input logic [23:0] expData,
                               input logic [1:0] expChan, input logic [3:0] expGrant);
        checkVal({tag, " o_wr"}, 32'(wr), 32'(expWr));
        checkVal({tag, " o_grant"}, 32'(grant), 32'(expGrant));
        if (expWr) begin
            checkVal({tag, " o_wdata"}, 32'(wdata), 32'(expData));
            checkVal({tag, " o_chan"}, 32'(chan), 32'(expChan));
        end
    endtask

    task automatic checkB(input string tag, input logic expWr, input logic [7:0] expData,
                          input logic expChan, input logic [1:0] expGrant);
        checkVal({tag, " B o_wr"}, 32'(wrB), 32'(expWr));
        checkVal({tag, " B o_grant"}, 32'(grantB), 32'(expGrant));
        if (expWr) begin
            checkVal({tag, " B o_wdata"}, 32'(wdataB), 32'(expData));
            checkVal({tag, " B o_chan"}, 32'(chanB), 32'(expChan));
        end
    endtask

    initial begin
        nAsserts = 0;
        nFail    = 0;
        rst      = 1'b0;
        wfull    = 1'b0;
        wfullB   = 1'b0;
        validB   = 2'b00;
        dataB    = {8'hB1, 8'hA0};
        srcEn    = 4'b0000;
        clearSources();
        driveSources();
        repeat (2) applyStimulus();

        $display("[TB] reset state");
        checkVal("rst o_wr", 32'(wr), 32'd0);
        checkVal("rst o_wdata", 32'(wdata), 32'd0);
        checkVal("rst o_chan", 32'(chan), 32'd0);
        checkVal("rst o_grant", 32'(grant), 32'd0);
        checkVal("rst o_ready", 32'(ready), 32'd0);

        $display("[TB] single-channel burst");
        srcEn   = 4'b0100;
        base[2] = 'h10;
        lim[2]  = 8;
        driveSources();
        rst = 1'b1;
        applyStimulus();
        checkOutput("t1 arb", 1'b0, 24'h0, 2'd0, 4'b0100);
        checkVal("t1 o_ready", 32'(ready), 32'b0100);
        for (int b = 0; b < 4; b++) begin
            applyStimulus();
            checkOutput("t1 beatA", 1'b1, 24'(32'h10 + b), 2'd2, (b < 3) ? 4'b0100 : 4'b0000);
        end
        applyStimulus();
        checkOutput("t1 gap", 1'b0, 24'h0, 2'd0, 4'b0100);
        for (int b = 0; b < 4; b++) begin
            applyStimulus();
            checkOutput("t1 beatB", 1'b1, 24'(32'h14 + b), 2'd2, (b < 3) ? 4'b0100 : 4'b0000);
        end
        applyStimulus();
        checkOutput("t1 idle", 1'b0, 24'h0, 2'd0, 4'b0000);

        $display("[TB] round-robin fairness");
        rst   = 1'b0;
        srcEn = 4'b1111;
        clearSources();
        for (int k = 0; k < 4; k++) begin
            base[k] = k * 'h100;
            lim[k]  = 8;
        end
        driveSources();
        applyStimulus();
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus();
                checkOutput("t2 arb", 1'b0, 24'h0, 2'd0, 4'b0001 << c);
                for (int b = 0; b < 4; b++) begin
                    applyStimulus();
                    checkOutput("t2 beat", 1'b1, 24'(c * 'h100 + r * 4 + b), 2'(c),
                                (b < 3) ? (4'b0001 << c) : 4'b0000);
                end
            end
        end

        $display("[TB] backpressure");
        rst   = 1'b0;
        srcEn = 4'b0010;
        clearSources();
        base[1] = 'hA00;
        lim[1]  = 4;
        driveSources();
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("t3 arb", 1'b0, 24'h0, 2'd0, 4'b0010);
        checkVal("t3 o_ready", 32'(ready), 32'b0010);
        for (int b = 0; b < 2; b++) begin
            applyStimulus();
            checkOutput("t3 pre", 1'b1, 24'(32'hA00 + b), 2'd1, 4'b0010);
        end
        wfull = 1'b1;
        for (int s = 0; s < 5; s++) begin
            applyStimulus();
            checkVal("t3 stall o_ready", 32'(ready), 32'd0);
            checkOutput("t3 stall", 1'b0, 24'h0, 2'd0, 4'b0010);
        end
        wfull = 1'b0;
        for (int b = 2; b < 4; b++) begin
            applyStimulus();
            checkOutput("t3 post", 1'b1, 24'(32'hA00 + b), 2'd1, (b < 3) ? 4'b0010 : 4'b0000);
        end
        applyStimulus();
        checkOutput("t3 idle", 1'b0, 24'h0, 2'd0, 4'b0000);

        $display("[TB] yield");
        srcEn = 4'b1001;
        clearSources();
        base[3] = 'h300;
        lim[3]  = 1;
        base[0] = 'h050;
        lim[0]  = 4;
        driveSources();
        applyStimulus();
        checkOutput("t4 arb3", 1'b0, 24'h0, 2'd0, 4'b1000);
        applyStimulus();
        checkOutput("t4 beat3", 1'b1, 24'h300, 2'd3, 4'b1000);
        applyStimulus();
        checkOutput("t4 yield", 1'b0, 24'h0, 2'd0, 4'b0000);
        applyStimulus();
        checkOutput("t4 arb0", 1'b0, 24'h0, 2'd0, 4'b0001);
        for (int b = 0; b < 4; b++) begin
            applyStimulus();
            checkOutput("t4 beat0", 1'b1, 24'(32'h050 + b), 2'd0, (b < 3) ? 4'b0001 : 4'b0000);
        end

        $display("[TB] reset mid-burst");
        srcEn = 4'b0010;
        clearSources();
        base[1] = 'h110;
        lim[1]  = 8;
        driveSources();
        applyStimulus();
        checkOutput("t5 arb", 1'b0, 24'h0, 2'd0, 4'b0010);
        for (int b = 0; b < 2; b++) begin
            applyStimulus();
            checkOutput("t5 beat", 1'b1, 24'(32'h110 + b), 2'd1, 4'b0010);
        end
        rst = 1'b0;
        applyStimulus();
        checkVal("t5 rst o_wr", 32'(wr), 32'd0);
        checkVal("t5 rst o_wdata", 32'(wdata), 32'd0);
        checkVal("t5 rst o_chan", 32'(chan), 32'd0);
        checkVal("t5 rst o_grant", 32'(grant), 32'd0);
        checkVal("t5 rst o_ready", 32'(ready), 32'd0);
        srcEn   = 4'b0110;
        base[2] = 'h220;
        lim[2]  = 8;
        driveSources();
        rst = 1'b1;
        applyStimulus();
        checkOutput("t5 regrant", 1'b0, 24'h0, 2'd0, 4'b0010);
        applyStimulus();
        checkOutput("t5 resume", 1'b1, 24'h112, 2'd1, 4'b0010);

        $display("[TB] wrap, sparse requests and BURST=1");
        rst   = 1'b0;
        srcEn = 4'b1000;
        clearSources();
        base[3] = 'h777;
        lim[3]  = 8;
        validB  = 2'b11;
        driveSources();
        applyStimulus();
        checkB("t6 rst", 1'b0, 8'h0, 1'b0, 2'b00);
        rst = 1'b1;
        applyStimulus();
        checkOutput("t6 arb", 1'b0, 24'h0, 2'd0, 4'b1000);
        checkB("t6 c1", 1'b0, 8'h0, 1'b0, 2'b01);
        applyStimulus();
        checkOutput("t6 beat0", 1'b1, 24'h777, 2'd3, 4'b1000);
        checkB("t6 c2", 1'b1, 8'hA0, 1'b0, 2'b00);
        applyStimulus();
        checkOutput("t6 beat1", 1'b1, 24'h778, 2'd3, 4'b1000);
        checkB("t6 c3", 1'b0, 8'h0, 1'b0, 2'b10);
        applyStimulus();
        checkOutput("t6 beat2", 1'b1, 24'h779, 2'd3, 4'b1000);
        checkB("t6 c4", 1'b1, 8'hB1, 1'b1, 2'b00);
        applyStimulus();
        checkOutput("t6 beat3", 1'b1, 24'h77A, 2'd3, 4'b0000);
        checkB("t6 c5", 1'b0, 8'h0, 1'b0, 2'b01);
        applyStimulus();
        checkOutput("t6 rearb", 1'b0, 24'h0, 2'd0, 4'b1000);
        applyStimulus();
        checkOutput("t6 beat4", 1'b1, 24'h77B, 2'd3, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
